// File: rtl/div_mode_sequencer.sv
// Mode-select sequencer for the FMDLL clock divider: gates clk2/clk4, holds the
// divider in reset while M switches, waits for it to settle, then re-enables.
//
// state  | meaning
// IDLE   | outputs enabled, requests evaluated
// GATE   | outputs gated, divider still running
// HOLD   | divider in reset, new M applied on first cycle
// SETTLE | divider released, outputs still gated
module div_mode_sequencer #(
  parameter int         GATE_CYC   = 4,
  parameter int         RST_CYC    = 2,
  parameter int         SETTLE_CYC = 8,
  parameter int         CNT_W      = 4,
  parameter logic [1:0] RST_M      = 2'd1
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] req_m,
  output logic       ack,
  output logic       err,
  output logic       done,
  output logic       busy,
  output logic [1:0] m_out,
  output logic       div_rst,
  output logic       clk_en
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (GATE_CYC < 1 || GATE_CYC > CNT_MAX ||
      RST_CYC < 1 || RST_CYC > CNT_MAX ||
      SETTLE_CYC < 1 || SETTLE_CYC > CNT_MAX) begin : g_param_check
    $error("div_mode_sequencer: phase length out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, GATE, HOLD, SETTLE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       m_pend, m_pend_nxt;
  logic             ack_nxt, err_nxt, done_nxt;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_ONE;
    m_pend_nxt = m_pend;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req) begin
          if (req_m == 2'd0) begin
            err_nxt = 1'b1;
          end else if (req_m == m_out) begin
            ack_nxt  = 1'b1;
            done_nxt = 1'b1;
          end else begin
            ack_nxt    = 1'b1;
            m_pend_nxt = req_m;
            state_nxt  = GATE;
          end
        end
      end
      GATE: begin
        if (cnt == GATE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == RST_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      m_pend  <= RST_M;
      m_out   <= RST_M;
      div_rst <= 1'b1;
      clk_en  <= 1'b0;
      busy    <= 1'b1;
      ack     <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      m_pend  <= m_pend_nxt;
      // M only moves on the edge into HOLD, so the divider is already in reset
      if (state != HOLD && state_nxt == HOLD)
        m_out <= m_pend;
      div_rst <= (state_nxt == HOLD);
      clk_en  <= (state_nxt == IDLE);
      busy    <= (state_nxt != IDLE);
      ack     <= ack_nxt;
      err     <= err_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_div_mode_sequencer.sv
// Directed bench for div_mode_sequencer: default-parameter instance plus a
// short-gate/long-settle instance, outputs packed as {ack,err,done,busy,div_rst,clk_en,m_out}.
module tb_div_mode_sequencer;

  logic       clk_ext = 1'b0;
  logic       rst, req, req2;
  logic [1:0] req_m, req_m2;
  logic       ack1, err1, done1, busy1, div_rst1, clk_en1;
  logic [1:0] m_out1;
  logic       ack2, err2, done2, busy2, div_rst2, clk_en2;
  logic [1:0] m_out2;
  logic [7:0] o1, o2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk_ext = ~clk_ext;

  div_mode_sequencer dut1 (
    .clk_ext(clk_ext), .rst(rst), .req(req), .req_m(req_m),
    .ack(ack1), .err(err1), .done(done1), .busy(busy1),
    .m_out(m_out1), .div_rst(div_rst1), .clk_en(clk_en1)
  );

  div_mode_sequencer #(.GATE_CYC(1), .RST_CYC(1), .SETTLE_CYC(15)) dut2 (
    .clk_ext(clk_ext), .rst(rst), .req(req2), .req_m(req_m2),
    .ack(ack2), .err(err2), .done(done2), .busy(busy2),
    .m_out(m_out2), .div_rst(div_rst2), .clk_en(clk_en2)
  );

  assign o1 = {ack1, err1, done1, busy1, div_rst1, clk_en1, m_out1};
  assign o2 = {ack2, err2, done2, busy2, div_rst2, clk_en2, m_out2};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  // Expected outputs k cycles after a request for M=nw accepted from M=od
  function automatic logic [7:0] exp_sw(input int k, input int g, input int r,
                                        input int s, input logic [1:0] od,
                                        input logic [1:0] nw);
    int l;
    l = 1 + g + r + s;
    return {(k == 1), 1'b0, (k == l), (k < l), (k > g && k <= g + r),
            (k >= l), (k > g) ? nw : od};
  endfunction

  task automatic startup_check();
    for (int k = 0; k <= 10; k++) begin
      chk("startup", o1, {1'b0, 1'b0, (k == 10), (k < 10), (k < 2), (k == 10), 2'd1});
      if (k < 10) step();
    end
    step();
  endtask

  task automatic do_switch(input logic [1:0] od, input logic [1:0] nw);
    req = 1'b1;
    req_m = nw;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) req = 1'b0;
      chk("switch", o1, exp_sw(k, 4, 2, 8, od, nw));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; req = 1'b0; req_m = 2'd0; req2 = 1'b0; req_m2 = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset", o1, 8'b0001_1001);
    end
    rst = 1'b0;
    startup_check();

    do_switch(2'd1, 2'd2);

    req = 1'b1; req_m = 2'd0;
    step();
    req = 1'b0;
    chk("reject", o1, 8'b0100_0110);
    step();
    chk("reject_idle", o1, 8'b0000_0110);

    req = 1'b1; req_m = 2'd2;
    step();
    req = 1'b0;
    chk("same_m", o1, 8'b1010_0110);
    step();
    chk("same_m_idle", o1, 8'b0000_0110);

    do_switch(2'd2, 2'd1);

    // busy collision, request dropped before IDLE
    req = 1'b1; req_m = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("coll_a", o1, exp_sw(k, 4, 2, 8, 2'd1, 2'd2));
      if (k == 1) req = 1'b0;
      if (k == 3) begin req = 1'b1; req_m = 2'd3; end
      if (k == 4) req = 1'b0;
    end

    // busy collision, request held until re-evaluated in IDLE
    req = 1'b1; req_m = 2'd1;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k <= 15) chk("coll_b", o1, exp_sw(k, 4, 2, 8, 2'd2, 2'd1));
      else         chk("coll_b2", o1, exp_sw(k - 15, 4, 2, 8, 2'd1, 2'd3));
      if (k == 1) req = 1'b0;
      if (k == 3) begin req = 1'b1; req_m = 2'd3; end
      if (k == 16) req = 1'b0;
    end

    // reset during HOLD after M already switched
    req = 1'b1; req_m = 2'd2;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req = 1'b0;
      chk("pre_rst", o1, exp_sw(k, 4, 2, 8, 2'd3, 2'd2));
    end
    rst = 1'b1;
    step();
    chk("mid_rst", o1, 8'b0001_1001);
    rst = 1'b0;
    startup_check();

    // short gate / long settle instance
    for (int i = 0; i < 8; i++) step();
    chk("sweep_idle", o2, 8'b0000_0101);
    req2 = 1'b1; req_m2 = 2'd2;
    w = 0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) req2 = 1'b0;
      if (div_rst2) w++;
      chk("sweep", o2, exp_sw(k, 1, 1, 15, 2'd1, 2'd2));
    end
    chk("sweep_rst_width", 8'(w), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
